// File: rtl/wb_stage_if.sv
// Bundle between the memory/decode stages and the writeback stage.
// Carries the incoming M-stage fields, W-register control, the two decode
// read ports and the registered W-stage forwarding sources.
interface wb_stage_if #(
   parameter int W = 64
);
   logic [3:0]   m_icode;
   logic         m_cnd;
   logic [3:0]   m_stat;
   logic [W-1:0] m_valE;
   logic [W-1:0] m_valM;
   logic [3:0]   m_dstE;
   logic [3:0]   m_dstM;
   logic         w_stall;
   logic         w_bubble;
   logic [3:0]   srcA;
   logic [3:0]   srcB;
   logic [W-1:0] valA;
   logic [W-1:0] valB;
   logic [3:0]   W_icode;
   logic [3:0]   W_stat;
   logic [W-1:0] W_valE;
   logic [W-1:0] W_valM;
   logic [3:0]   W_dstE;
   logic [3:0]   W_dstM;
   logic         halted;

   // Pipeline side: drives M-stage fields, controls and read addresses
   modport master (
      output m_icode, m_cnd, m_stat, m_valE, m_valM, m_dstE, m_dstM,
      output w_stall, w_bubble, srcA, srcB,
      input  valA, valB, W_icode, W_stat, W_valE, W_valM, W_dstE, W_dstM, halted
   );

   // Writeback stage side
   modport slave (
      input  m_icode, m_cnd, m_stat, m_valE, m_valM, m_dstE, m_dstM,
      input  w_stall, w_bubble, srcA, srcB,
      output valA, valB, W_icode, W_stat, W_valE, W_valM, W_dstE, W_dstM, halted
   );
endinterface

// File: rtl/wb_stage.sv
// Y86-64 writeback stage: W pipeline register, 15-entry program register
// file with two combinational read ports, and a run/halt state machine that
// stops architectural updates once a non-AOK status reaches W.
module wb_stage #(
   parameter int NREG = 15,
   parameter int W    = 64
) (
   input  logic     clk,
   input  logic     rst,
   wb_stage_if.slave bus
);
   localparam logic [3:0] RNONE  = 4'hF;
   localparam logic [3:0] I_NOP  = 4'h1;
   localparam logic [3:0] I_CMOV = 4'h2;
   localparam logic [3:0] S_AOK  = 4'h1;

   typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

   state_t       state_q, state_d;
   logic [3:0]   w_icode_q, w_icode_d;
   logic [3:0]   w_stat_q,  w_stat_d;
   logic [W-1:0] w_vale_q,  w_vale_d;
   logic [W-1:0] w_valm_q,  w_valm_d;
   logic [3:0]   w_dste_q,  w_dste_d;
   logic [3:0]   w_dstm_q,  w_dstm_d;
   logic [W-1:0] rf_q [NREG];
   logic         commit;
   logic [W-1:0] val_a, val_b;

   // Only an AOK instruction sitting in W while running may touch the register file
   assign commit = (state_q == RUN) && (w_stat_q == S_AOK);

   // Next W register contents: hold on stall or halt, nop on bubble, else capture
   always_comb begin
      w_icode_d = w_icode_q;
      w_stat_d  = w_stat_q;
      w_vale_d  = w_vale_q;
      w_valm_d  = w_valm_q;
      w_dste_d  = w_dste_q;
      w_dstm_d  = w_dstm_q;
      state_d   = state_q;
      if (state_q == RUN) begin
         if (w_stat_q != S_AOK) begin
            state_d = HALTED;
         end
         if (!bus.w_stall) begin
            if (bus.w_bubble) begin
               w_icode_d = I_NOP;
               w_stat_d  = S_AOK;
               w_vale_d  = '0;
               w_valm_d  = '0;
               w_dste_d  = RNONE;
               w_dstm_d  = RNONE;
            end else begin
               w_icode_d = bus.m_icode;
               w_stat_d  = bus.m_stat;
               w_vale_d  = bus.m_valE;
               w_valm_d  = bus.m_valM;
               // A cmov whose condition failed writes nothing
               w_dste_d  = (bus.m_icode == I_CMOV && !bus.m_cnd) ? RNONE : bus.m_dstE;
               w_dstm_d  = bus.m_dstM;
            end
         end
      end
   end

   // W pipeline register and run/halt state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         w_icode_q <= I_NOP;
         w_stat_q  <= S_AOK;
         w_vale_q  <= '0;
         w_valm_q  <= '0;
         w_dste_q  <= RNONE;
         w_dstm_q  <= RNONE;
      end else begin
         state_q   <= state_d;
         w_icode_q <= w_icode_d;
         w_stat_q  <= w_stat_d;
         w_vale_q  <= w_vale_d;
         w_valm_q  <= w_valm_d;
         w_dste_q  <= w_dste_d;
         w_dstm_q  <= w_dstm_d;
      end
   end

   // One flop bank per program register; the M port has priority so popq %rsp keeps valM
   for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
      logic we_e, we_m;
      assign we_e = commit && (w_dste_q == 4'(gi));
      assign we_m = commit && (w_dstm_q == 4'(gi));

      // Commit the W-stage result into this register
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            rf_q[gi] <= '0;
         end else if (we_m) begin
            rf_q[gi] <= w_valm_q;
         end else if (we_e) begin
            rf_q[gi] <= w_vale_q;
         end
      end
   end

   // Decode read ports: plain mux over the array, IDs with no entry read 0
   always_comb begin
      val_a = '0;
      val_b = '0;
      for (int i = 0; i < NREG; i++) begin
         if (bus.srcA == 4'(i)) val_a = rf_q[i];
         if (bus.srcB == 4'(i)) val_b = rf_q[i];
      end
   end

   assign bus.valA    = val_a;
   assign bus.valB    = val_b;
   assign bus.W_icode = w_icode_q;
   assign bus.W_stat  = w_stat_q;
   assign bus.W_valE  = w_vale_q;
   assign bus.W_valM  = w_valm_q;
   assign bus.W_dstE  = w_dste_q;
   assign bus.W_dstM  = w_dstm_q;
   assign bus.halted  = (state_q == HALTED);
endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the writeback stage.
module tb_wb_stage;
   logic clk;
   logic rst;

   wb_stage_if #(.W(64)) bus ();

   wb_stage #(.NREG(15), .W(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // ---------------- behavioural model ----------------
   logic [63:0] mdl_rf [15];
   logic [3:0]  mdl_icode, mdl_stat, mdl_dste, mdl_dstm;
   logic [63:0] mdl_vale, mdl_valm;
   bit          mdl_halted;

   // Retire the instruction in W, then advance W, on each edge while running
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 15; i++) mdl_rf[i] = 64'd0;
         mdl_icode = 4'd1; mdl_stat = 4'd1;
         mdl_dste = 4'hF;  mdl_dstm = 4'hF;
         mdl_vale = 64'd0; mdl_valm = 64'd0;
         mdl_halted = 1'b0;
      end else if (!mdl_halted) begin
         if (mdl_stat == 4'd1) begin
            if (mdl_dste != 4'hF) mdl_rf[mdl_dste] = mdl_vale;
            if (mdl_dstm != 4'hF) mdl_rf[mdl_dstm] = mdl_valm;
         end
         if (mdl_stat != 4'd1) mdl_halted = 1'b1;
         if (bus.w_stall) begin
            // hold
         end else if (bus.w_bubble) begin
            mdl_icode = 4'd1; mdl_stat = 4'd1;
            mdl_dste = 4'hF;  mdl_dstm = 4'hF;
            mdl_vale = 64'd0; mdl_valm = 64'd0;
         end else begin
            mdl_icode = bus.m_icode;
            mdl_stat  = bus.m_stat;
            mdl_vale  = bus.m_valE;
            mdl_valm  = bus.m_valM;
            mdl_dste  = (bus.m_icode == 4'd2 && !bus.m_cnd) ? 4'hF : bus.m_dstE;
            mdl_dstm  = bus.m_dstM;
         end
      end
   end

   function automatic logic [63:0] mdl_read(input logic [3:0] id);
      return (id == 4'hF) ? 64'd0 : mdl_rf[id];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_W_icode", 64'(bus.W_icode), 64'(mdl_icode));
         check("cyc_W_stat",  64'(bus.W_stat),  64'(mdl_stat));
         check("cyc_W_valE",  bus.W_valE,       mdl_vale);
         check("cyc_W_valM",  bus.W_valM,       mdl_valm);
         check("cyc_W_dstE",  64'(bus.W_dstE),  64'(mdl_dste));
         check("cyc_W_dstM",  64'(bus.W_dstM),  64'(mdl_dstm));
         check("cyc_halted",  64'(bus.halted),  64'(mdl_halted));
         check("cyc_valA",    bus.valA,         mdl_read(bus.srcA));
         check("cyc_valB",    bus.valB,         mdl_read(bus.srcB));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic [3:0] ic, input logic c, input logic [3:0] st,
                        input logic [63:0] ve, input logic [63:0] vm,
                        input logic [3:0] de, input logic [3:0] dm);
      bus.m_icode = ic; bus.m_cnd = c; bus.m_stat = st;
      bus.m_valE = ve;  bus.m_valM = vm;
      bus.m_dstE = de;  bus.m_dstM = dm;
   endtask

   task automatic drive_nop();
      drive(4'd1, 1'b1, 4'd1, 64'd0, 64'd0, 4'hF, 4'hF);
   endtask

   // Advance one edge; return just after the following falling edge
   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   function automatic logic [3:0] rand_id();
      return ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
   endfunction

   initial begin
      rst = 1'b1;
      drive_nop();
      bus.w_stall = 1'b0; bus.w_bubble = 1'b0;
      bus.srcA = 4'd0; bus.srcB = 4'd0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      rst = 1'b0;
      chk_en = 1'b1;
      #1;
      check("rst_W_icode", 64'(bus.W_icode), 64'd1);
      check("rst_W_dstE",  64'(bus.W_dstE),  64'hF);
      check("rst_halted",  64'(bus.halted),  64'd0);
      check("rst_valA",    bus.valA,         64'd0);

      // irmovq $0x2A, %rdx
      drive(4'd3, 1'b1, 4'd1, 64'h2A, 64'd0, 4'd2, 4'hF);
      bus.srcA = 4'd2;
      next_cycle();
      check("irm_W_dstE", 64'(bus.W_dstE), 64'd2);
      check("irm_valA_before", bus.valA, 64'd0);
      drive_nop();
      next_cycle();
      check("irm_valA_after", bus.valA, 64'h2A);

      // popq %rsp style: both ports target reg 4, valM must win
      drive(4'hB, 1'b1, 4'd1, 64'h100, 64'h55, 4'd4, 4'd4);
      next_cycle();
      check("pop_W_icode", 64'(bus.W_icode), 64'hB);
      drive_nop();
      bus.srcA = 4'd4;
      next_cycle();
      check("pop_valA", bus.valA, 64'h55);

      // cmov not taken, then taken
      drive(4'd2, 1'b0, 4'd1, 64'd7, 64'd0, 4'd3, 4'hF);
      next_cycle();
      check("cmov0_W_dstE", 64'(bus.W_dstE), 64'hF);
      drive_nop();
      bus.srcA = 4'd3;
      next_cycle();
      check("cmov0_reg3", bus.valA, 64'd0);
      drive(4'd2, 1'b1, 4'd1, 64'd7, 64'd0, 4'd3, 4'hF);
      next_cycle();
      check("cmov1_W_dstE", 64'(bus.W_dstE), 64'd3);
      drive_nop();
      next_cycle();
      check("cmov1_reg3", bus.valA, 64'd7);

      // stall / bubble
      drive(4'd6, 1'b1, 4'd1, 64'h99, 64'd0, 4'd5, 4'hF);
      next_cycle();
      check("opq_W_dstE", 64'(bus.W_dstE), 64'd5);
      drive(4'd3, 1'b1, 4'd1, 64'h77, 64'd0, 4'd7, 4'hF);
      bus.w_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         check("stall_W_dstE", 64'(bus.W_dstE), 64'd5);
         check("stall_W_valE", bus.W_valE,      64'h99);
      end
      bus.w_bubble = 1'b1;
      next_cycle();
      check("stallbub_W_icode", 64'(bus.W_icode), 64'd6);
      bus.w_stall = 1'b0;
      next_cycle();
      check("bub_W_icode", 64'(bus.W_icode), 64'd1);
      check("bub_W_dstE",  64'(bus.W_dstE),  64'hF);
      bus.w_bubble = 1'b0;
      bus.srcB = 4'd5;
      #1;
      check("stall_reg5", bus.valB, 64'h99);
      bus.srcB = 4'd7;
      #1;
      check("stall_reg7", bus.valB, 64'd0);

      // halt: HLT retiring with a destination must not write
      drive(4'd0, 1'b1, 4'd2, 64'd9, 64'd0, 4'd6, 4'hF);
      next_cycle();
      check("hlt_W_stat", 64'(bus.W_stat), 64'd2);
      next_cycle();
      check("hlt_halted", 64'(bus.halted), 64'd1);
      bus.srcA = 4'd6;
      #1;
      check("hlt_reg6", bus.valA, 64'd0);
      drive(4'd6, 1'b1, 4'd1, 64'h1234, 64'd0, 4'd8, 4'hF);
      bus.srcB = 4'd8;
      repeat (3) next_cycle();
      check("hlt_frozen_stat", 64'(bus.W_stat), 64'd2);
      check("hlt_frozen_dstE", 64'(bus.W_dstE), 64'd6);
      check("hlt_still",       64'(bus.halted), 64'd1);
      check("hlt_reg8",        bus.valB,        64'd0);

      // asynchronous reset between edges
      bus.srcA = 4'd2;
      #2 rst = 1'b1;
      #1;
      check("arst_halted",  64'(bus.halted),  64'd0);
      check("arst_W_icode", 64'(bus.W_icode), 64'd1);
      check("arst_W_stat",  64'(bus.W_stat),  64'd1);
      check("arst_W_dstE",  64'(bus.W_dstE),  64'hF);
      check("arst_W_valE",  bus.W_valE,       64'd0);
      check("arst_reg2",    bus.valA,         64'd0);
      @(negedge clk); #1;
      rst = 1'b0;

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         drive(4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 39) == 0) ? 4'($urandom_range(2, 4)) : 4'd1,
               {$urandom, $urandom}, {$urandom, $urandom}, rand_id(), rand_id());
         bus.w_stall  = ($urandom_range(0, 7) == 0);
         bus.w_bubble = ($urandom_range(0, 7) == 0);
         bus.srcA = 4'($urandom_range(0, 15));
         bus.srcB = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 59) == 0) begin
            #1 rst = 1'b1;
            #2 rst = 1'b0;
         end
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
